// File: rtl/reg_file_pkg.sv
// Shared constants for the parametrised MIPS register file: default sizing,
// the hardwired-zero index and the ABI register names.
package reg_file_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NRD   = 2;

  localparam int ZERO_REG  = 0;
  localparam int REG_AT    = 1;
  localparam int REG_V0    = 2;
  localparam int REG_V1    = 3;
  localparam int REG_A0    = 4;
  localparam int REG_T0    = 8;
  localparam int REG_S0    = 16;
  localparam int REG_GP    = 28;
  localparam int REG_SP    = 29;
  localparam int REG_FP    = 30;
  localparam int REG_RA    = 31;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by a decode
// reservation, cleared by writeback or flush, with a running popcount.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int NRD   = DEF_NRD,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] lookup_addr,
  output logic [NRD-1:0]    lookup_busy,
  output logic              set_ok,
  output logic [AW:0]       busy_cnt
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [AW:0]      cnt_next;
  logic             do_set;
  logic             do_clr;

  // Only a clear of a register that really is busy moves the count down, so
  // a write to an idle register and a same-address set+clear stay balanced.
  always_comb begin
    set_ok    = set_en & ~busy[set_addr] & ~flush;
    do_set    = set_ok & (set_addr != ZERO_ADDR);
    do_clr    = clr_en & (clr_addr != ZERO_ADDR) & busy[clr_addr];
    busy_next = busy;
    if (do_clr) busy_next[clr_addr] = 1'b0;
    if (do_set) busy_next[set_addr] = 1'b1;
    cnt_next  = busy_cnt + (AW+1)'(do_set) - (AW+1)'(do_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else if (flush) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

  always_comb begin
    lookup_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      lookup_busy[i] = busy[lookup_addr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with hardwired-zero r0 and a reservation
// scoreboard. Define REG_FILE_SB_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NRD   = DEF_NRD,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_ready,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rsv_ok,
  input  logic                 flush,
  output logic [AW:0]          busy_cnt
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [NRD-1:0]   port_busy;
  logic             wr_live;

  assign wr_live = wr_en && (wr_addr != ZERO_ADDR);

  reg_scoreboard #(
    .DEPTH (DEPTH),
    .NRD   (NRD),
    .AW    (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (rsv_en),
    .set_addr    (rsv_addr),
    .clr_en      (wr_en),
    .clr_addr    (wr_addr),
    .flush       (flush),
    .lookup_addr (rd_addr),
    .lookup_busy (port_busy),
    .set_ok      (rsv_ok),
    .busy_cnt    (busy_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // r0 short-circuits to zero/ready before either the array or forwarding.
  always_comb begin
    rd_data  = '0;
    rd_ready = '1;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*AW +: AW] != ZERO_ADDR) begin
        rd_data[i*WIDTH +: WIDTH] = regs[rd_addr[i*AW +: AW]];
        rd_ready[i]               = ~port_busy[i];
`ifdef REG_FILE_SB_BYPASS_EN
        if (wr_live && (wr_addr == rd_addr[i*AW +: AW])) begin
          rd_data[i*WIDTH +: WIDTH] = wr_data;
          rd_ready[i]               = 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-write/dual-read MIPS register file.
- Adds a configurable number of read ports, a posedge synchronous write, hardwired-zero register 0, and a per-register pending-write scoreboard with a reservation handshake.
- Sits between decode (reads and reservations) and writeback (writes) of the pipelined core, so decode can stall on RAW/WAW hazards against long-latency results.

Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers; power of two, at least 2
- NRD, 2, number of read ports, 1 to 4
- AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NRD*WIDTH  packed read data, combinational
- rd_ready  out  NRD  1 = register not pending (data usable)
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  WIDTH  writeback value
- rsv_en  in  1  decode requests ownership of rsv_addr
- rsv_addr  in  AW  register to reserve
- rsv_ok  out  1  combinational grant for the current rsv_en
- flush  in  1  synchronous clear of all pending bits (pipeline squash)
- busy_cnt  out  AW+1  number of registers currently pending

Behaviour:
- Reset (asynchronous, rst=1):
  - All registers are cleared to 0; there are no preset values.
  - All busy bits clear; busy_cnt=0.
  - Every rd_data reads 0 and every rd_ready reads 1.
- Read:
  - rd_data[i] = reg[rd_addr[i]], combinational with zero latency.
  - Address 0 always returns 0 with rd_ready=1.
  - rd_ready[i] = ~busy[rd_addr[i]].
- Write:
  - When wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data at posedge.
  - The same edge clears busy[wr_addr].
  - A write to address 0 is discarded.
  - A write to a non-busy register is legal: data is written, busy stays 0.
- Reservation:
  - rsv_ok = rsv_en & ~busy[rsv_addr] & ~flush. A reservation of address 0 always gets rsv_ok=1 and never sets busy.
  - On rsv_ok with rsv_addr!=0, busy[rsv_addr] <= 1 at posedge.
  - A register already busy gets rsv_ok=0 (WAW stall), and its state is unchanged.
- Same cycle, wr_addr==rsv_addr!=0, busy=1: rsv_ok=0 this cycle. The write lands and clears busy; the next cycle's retry is granted.
- Same cycle, wr_addr==rsv_addr!=0, busy=0: the write lands, busy is set, and rsv_ok=1. The new owner wins.
- Flush:
  - At posedge, all busy bits are cleared and busy_cnt becomes 0.
  - A same-cycle write still updates data.
  - A same-cycle reservation is refused (rsv_ok=0).
- busy_cnt:
  - Registered, always equal to popcount(busy).
  - Net change per cycle is in {-1, 0, +1}: +1 for a granted set, -1 for a clear by write of a busy register, 0 when both occur.
  - Never exceeds DEPTH-1.
- Reset asserted mid-operation overrides every input on the same edge. There are no partial updates.

Optional Feature:
- Macro REG_FILE_SB_BYPASS_EN.
- When defined:
  - If wr_en=1, wr_addr!=0 and wr_addr==rd_addr[i], then rd_data[i]=wr_data and rd_ready[i]=1 in the same cycle (write-to-read forwarding).
  - Reads of address 0 are unaffected.
- When undefined:
  - Reads return the stored value; the new value is visible the cycle after the write edge.
  - rd_ready stays 0 during the writeback cycle of a pending register.

Decomposition:
- Package reg_file_pkg holds:
  - default WIDTH/DEPTH/NRD localparams
  - the ZERO_REG=0 constant
  - the ABI register-index constants (REG_SP=29, REG_RA=31, etc.)
- One sub-module, reg_scoreboard, owns:
  - the busy vector, rsv_ok logic, flush and busy_cnt
  - interface: clk, rst, set/clear strobes and addresses, per-port lookup.
- The top level owns the data array, the read muxes and the bypass.

Test Plan:
1. Reset then read: assert rst mid-run after writing reg5=0xDEADBEEF → all ports read 0x00000000 with rd_ready=1, busy_cnt=0.
2. Zero register: write reg0=0x12345678, then reserve reg0 → reads 0, rsv_ok=1, busy_cnt stays 0.
3. Reserve/writeback: reserve reg8 → rd_ready=0 on port reading 8, busy_cnt=1. Reserve reg8 again → rsv_ok=0. Write reg8=0xA5 → next cycle rd_data=0xA5, rd_ready=1, busy_cnt=0.
4. Simultaneous: reg9 busy, write reg9=0x1 and reserve reg9 same cycle → rsv_ok=0, reg9=0x1, busy clear. Retry → granted, busy_cnt=1.
5. Flush: reserve regs 1,2,3 (busy_cnt=3), then flush with concurrent write reg2=0x77 → busy_cnt=0, all ready, reg2=0x77.
6. Bypass: write reg4=0xCAFE while port 1 reads reg4 → 0xCAFE same cycle with REG_FILE_SB_BYPASS_EN defined, old value without it. Repeat with NRD=4, WIDTH=64.
